// File: rtl/bus_arb2.sv
// Two-master / one-slave command arbiter with an in-order ID queue that
// steers each slave response back to the master that issued the command.
module bus_arb2 #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int OUTS_DEPTH = 2,
   parameter int RR         = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_cmd_valid,
   output logic            m0_cmd_ready,
   input  logic [AW-1:0]   m0_cmd_addr,
   input  logic [DW-1:0]   m0_cmd_wdata,
   input  logic [DW/8-1:0] m0_cmd_wmask,
   input  logic            m0_cmd_wen,
   output logic            m0_rsp_valid,
   input  logic            m0_rsp_ready,
   output logic [DW-1:0]   m0_rsp_rdata,
   output logic            m0_rsp_err,
   input  logic            m1_cmd_valid,
   output logic            m1_cmd_ready,
   input  logic [AW-1:0]   m1_cmd_addr,
   input  logic [DW-1:0]   m1_cmd_wdata,
   input  logic [DW/8-1:0] m1_cmd_wmask,
   input  logic            m1_cmd_wen,
   output logic            m1_rsp_valid,
   input  logic            m1_rsp_ready,
   output logic [DW-1:0]   m1_rsp_rdata,
   output logic            m1_rsp_err,
   output logic            s_cmd_valid,
   input  logic            s_cmd_ready,
   output logic [AW-1:0]   s_cmd_addr,
   output logic [DW-1:0]   s_cmd_wdata,
   output logic [DW/8-1:0] s_cmd_wmask,
   output logic            s_cmd_wen,
   input  logic            s_rsp_valid,
   output logic            s_rsp_ready,
   input  logic [DW-1:0]   s_rsp_rdata,
   input  logic            s_rsp_err
);

   localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
   localparam int CW = $clog2(OUTS_DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(OUTS_DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(OUTS_DEPTH);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [OUTS_DEPTH-1:0] queue_q, queue_d;
   logic                  last_q, last_d;
   logic                  lock_q, lock_d;
   logic                  lock_id_q, lock_id_d;

   logic full, empty, grant, head, push, pop;

   assign full  = (cnt_q == CNT_FULL);
   assign empty = (cnt_q == '0);

   always_comb begin
      grant = 1'b0;
      if (lock_q) begin
         grant = lock_id_q;
      end else if (m0_cmd_valid && !m1_cmd_valid) begin
         grant = 1'b0;
      end else if (m1_cmd_valid && !m0_cmd_valid) begin
         grant = 1'b1;
      end else if (m0_cmd_valid && m1_cmd_valid) begin
         grant = (RR != 0) ? !last_q : 1'b1;
      end
   end

   // Full blocks new commands outright; a same-cycle pop does not bypass it.
   assign s_cmd_valid  = (grant ? m1_cmd_valid : m0_cmd_valid) & !full;
   assign s_cmd_addr   = grant ? m1_cmd_addr  : m0_cmd_addr;
   assign s_cmd_wdata  = grant ? m1_cmd_wdata : m0_cmd_wdata;
   assign s_cmd_wmask  = grant ? m1_cmd_wmask : m0_cmd_wmask;
   assign s_cmd_wen    = grant ? m1_cmd_wen   : m0_cmd_wen;
   assign m0_cmd_ready = s_cmd_ready & !full & !grant;
   assign m1_cmd_ready = s_cmd_ready & !full & grant;

   assign head         = queue_q[rptr_q];
   assign m0_rsp_valid = s_rsp_valid & !empty & !head;
   assign m1_rsp_valid = s_rsp_valid & !empty & head;
   assign m0_rsp_rdata = s_rsp_rdata;
   assign m1_rsp_rdata = s_rsp_rdata;
   assign m0_rsp_err   = s_rsp_err;
   assign m1_rsp_err   = s_rsp_err;
   assign s_rsp_ready  = (head ? m1_rsp_ready : m0_rsp_ready) & !empty;

   assign push = s_cmd_valid & s_cmd_ready;
   assign pop  = s_rsp_valid & s_rsp_ready;

   generate
      for (genvar gi = 0; gi < OUTS_DEPTH; gi++) begin : g_queue
         localparam logic [PW-1:0] IDX = PW'(gi);
         always_comb begin
            queue_d[gi] = queue_q[gi];
            if (push && (wptr_q == IDX)) begin
               queue_d[gi] = grant;
            end
         end
      end
   endgenerate

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (push) begin
         wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
         last_d = grant;
         lock_d = 1'b0;
      end else if (s_cmd_valid) begin
         // Stalled command: pin the grant until the slave takes it.
         lock_d    = 1'b1;
         lock_id_d = grant;
      end
      if (pop) begin
         rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         queue_q   <= '0;
         last_q    <= 1'b1;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         queue_q   <= queue_d;
         last_q    <= last_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

endmodule
